morra_cinese: RTL and testbench

MORRA_CINESE -- requirements
Module: morra_cinese

---
 rtl/morra_cinese_if.sv | 26 ++
 rtl/morra_cinese.sv | 232 +++++++++++++++++++++++
 tb/tb_morra_cinese.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/morra_cinese_if.sv
// Player-facing bus of the morra cinese (rock-paper-scissors) referee.
// Moves and the start strobe go from the master (players/host) to the slave (referee).
// The round and game verdicts go back from the slave to the master.
interface morra_cinese_if;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    modport master (
        output PRIMO,
        output SECONDO,
        output INIZIA,
        input  MANCHE,
        input  PARTITA
    );

    modport slave (
        input  PRIMO,
        input  SECONDO,
        input  INIZIA,
        output MANCHE,
        output PARTITA
    );
endinterface

// File: rtl/morra_cinese.sv
// Morra cinese (rock-paper-scissors) referee.
// The referee scores one round per clock and ends the game when one player
// leads by two or more after at least four valid rounds. It also ends the game
// when the configured round limit is reached.
// INIZIA starts or restarts a game. On that cycle {PRIMO,SECONDO}+4 gives the
// round limit (4..19).
// Optional feature: define MORRA_NO_REPEAT_EN to enable the no-repeat rule.
// With this rule, the winner of the last decisive round may not win again with
// the same move. If that player repeats the move, the round is invalid.
module morra_cinese (
    input  logic                 clk,
    input  logic                 rst,
    morra_cinese_if.slave        bus,
    output logic [4:0]           current_state,
    output logic [4:0]           next_state
);

    localparam logic [4:0] IDLE  = 5'b00001;
    localparam logic [4:0] PLAY  = 5'b00010;
    localparam logic [4:0] P1WIN = 5'b00100;
    localparam logic [4:0] P2WIN = 5'b01000;
    localparam logic [4:0] DRAW  = 5'b10000;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    // Raw outcome of one round: 00 if either move is missing, else P1/P2/tie.
    function automatic logic [1:0] round_result(input logic [1:0] p, input logic [1:0] s);
        logic [1:0] r;
        if ((p == 2'b00) || (s == 2'b00)) begin
            r = RES_NONE;
        end else if (p == s) begin
            r = RES_TIE;
        end else if (((p == 2'b01) && (s == 2'b11)) ||
                     ((p == 2'b11) && (s == 2'b10)) ||
                     ((p == 2'b10) && (s == 2'b01))) begin
            r = RES_P1;
        end else begin
            r = RES_P2;
        end
        return r;
    endfunction

    logic [4:0]        state_r;
    logic [4:0]        state_s;
    logic [4:0]        max_rounds_r;
    logic [4:0]        rounds_r;
    logic signed [5:0] lead_r;
    logic [1:0]        manche_r;
    logic [1:0]        partita_r;

    logic [4:0]        max_rounds_s;
    logic [4:0]        rounds_s;
    logic signed [5:0] lead_s;
    logic [1:0]        manche_s;
    logic [1:0]        partita_s;

    logic [1:0]        res_s;
    logic              valid_s;
    logic [4:0]        rounds_upd_s;
    logic signed [5:0] lead_upd_s;
    logic              game_over_s;
    logic [1:0]        verdict_s;

`ifdef MORRA_NO_REPEAT_EN
    logic [1:0]        last_winner_r;
    logic [1:0]        last_move_r;
    logic [1:0]        last_winner_s;
    logic [1:0]        last_move_s;
`endif

    // Score the current moves and derive the post-round count, lead and end condition.
    always_comb begin
        res_s   = round_result(bus.PRIMO, bus.SECONDO);
        valid_s = (res_s != RES_NONE);
`ifdef MORRA_NO_REPEAT_EN
        if (((last_winner_r == RES_P1) && (bus.PRIMO == last_move_r)) ||
            ((last_winner_r == RES_P2) && (bus.SECONDO == last_move_r))) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_s;
        end
`endif
        rounds_upd_s = rounds_r + 5'd1;
        if (res_s == RES_P1) begin
            lead_upd_s = lead_r + 6'sd1;
        end else if (res_s == RES_P2) begin
            lead_upd_s = lead_r - 6'sd1;
        end else begin
            lead_upd_s = lead_r;
        end
        game_over_s = ((rounds_upd_s >= 5'd4) &&
                       ((lead_upd_s >= 6'sd2) || (lead_upd_s <= -6'sd2))) ||
                      (rounds_upd_s == max_rounds_r);
        if (lead_upd_s > 6'sd0) begin
            verdict_s = RES_P1;
        end else if (lead_upd_s < 6'sd0) begin
            verdict_s = RES_P2;
        end else begin
            verdict_s = RES_TIE;
        end
    end

    // State register; reset beats INIZIA and any round in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: INIZIA restarts from anywhere, PLAY exits on a finished game.
    always_comb begin
        state_s = state_r;
        if (bus.INIZIA) begin
            state_s = PLAY;
        end else begin
            case (state_r)
                IDLE:  state_s = IDLE;
                PLAY: begin
                    if (valid_s && game_over_s) begin
                        case (verdict_s)
                            RES_P1:  state_s = P1WIN;
                            RES_P2:  state_s = P2WIN;
                            default: state_s = DRAW;
                        endcase
                    end else begin
                        state_s = PLAY;
                    end
                end
                P1WIN: state_s = P1WIN;
                P2WIN: state_s = P2WIN;
                DRAW:  state_s = DRAW;
                default: state_s = IDLE;
            endcase
        end
    end

    // Output/datapath logic: next values of verdicts, counters and repeat record.
    always_comb begin
        max_rounds_s = max_rounds_r;
        rounds_s     = rounds_r;
        lead_s       = lead_r;
        manche_s     = manche_r;
        partita_s    = partita_r;
`ifdef MORRA_NO_REPEAT_EN
        last_winner_s = last_winner_r;
        last_move_s   = last_move_r;
`endif
        if (bus.INIZIA) begin
            max_rounds_s = {1'b0, bus.PRIMO, bus.SECONDO} + 5'd4;
            rounds_s     = 5'd0;
            lead_s       = 6'sd0;
            manche_s     = RES_NONE;
            partita_s    = RES_NONE;
`ifdef MORRA_NO_REPEAT_EN
            last_winner_s = RES_NONE;
            last_move_s   = 2'b00;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    manche_s = manche_r;
                end
                PLAY: begin
                    if (valid_s) begin
                        manche_s  = res_s;
                        rounds_s  = rounds_upd_s;
                        lead_s    = lead_upd_s;
                        partita_s = game_over_s ? verdict_s : RES_NONE;
`ifdef MORRA_NO_REPEAT_EN
                        if (res_s == RES_P1) begin
                            last_winner_s = RES_P1;
                            last_move_s   = bus.PRIMO;
                        end else if (res_s == RES_P2) begin
                            last_winner_s = RES_P2;
                            last_move_s   = bus.SECONDO;
                        end else begin
                            last_winner_s = RES_NONE;
                            last_move_s   = 2'b00;
                        end
`endif
                    end else begin
                        manche_s  = RES_NONE;
                        partita_s = RES_NONE;
                    end
                end
                P1WIN, P2WIN, DRAW: begin
                    manche_s = RES_NONE;
                end
                default: begin
                    manche_s  = RES_NONE;
                    partita_s = RES_NONE;
                end
            endcase
        end
    end

    // Datapath registers holding the game context and the registered verdicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_rounds_r <= 5'd4;
            rounds_r     <= 5'd0;
            lead_r       <= 6'sd0;
            manche_r     <= RES_NONE;
            partita_r    <= RES_NONE;
`ifdef MORRA_NO_REPEAT_EN
            last_winner_r <= RES_NONE;
            last_move_r   <= 2'b00;
`endif
        end else begin
            max_rounds_r <= max_rounds_s;
            rounds_r     <= rounds_s;
            lead_r       <= lead_s;
            manche_r     <= manche_s;
            partita_r    <= partita_s;
`ifdef MORRA_NO_REPEAT_EN
            last_winner_r <= last_winner_s;
            last_move_r   <= last_move_s;
`endif
        end
    end

    assign bus.MANCHE    = manche_r;
    assign bus.PARTITA   = partita_r;
    assign current_state = state_r;
    assign next_state    = state_s;

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for morra_cinese: a game-level reference model is compared
// every cycle, with directed scenarios pinned to hand-computed values.
// Honours MORRA_NO_REPEAT_EN in the same way as the design.
module tb_morra_cinese;

    logic       clk;
    logic       rst;
    logic [4:0] current_state;
    logic [4:0] next_state;

    morra_cinese_if bus();

    morra_cinese dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .current_state (current_state),
        .next_state    (next_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phase: 0 idle, 1 playing, 2 P1 won, 3 P2 won, 4 draw
    typedef struct {
        int phase;
        int rounds;
        int lead;
        int maxr;
        int manche;
        int partita;
        int lw;
        int lm;
    } model_t;

    model_t model;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic model_t step(model_t m, bit r, bit ini, int p, int s);
        model_t n = m;
        int res;
        if (r) begin
            n.phase = 0; n.rounds = 0; n.lead = 0; n.maxr = 4;
            n.manche = 0; n.partita = 0; n.lw = 0; n.lm = 0;
        end else if (ini) begin
            n.phase = 1; n.rounds = 0; n.lead = 0; n.maxr = p * 4 + s + 4;
            n.manche = 0; n.partita = 0; n.lw = 0; n.lm = 0;
        end else if (m.phase == 1) begin
            if (p == 0 || s == 0) res = 0;
            else if (p == s) res = 3;
            else if ((p - s + 3) % 3 == 1) res = 1;
            else res = 2;
`ifdef MORRA_NO_REPEAT_EN
            if ((m.lw == 1 && p == m.lm) || (m.lw == 2 && s == m.lm)) res = 0;
`endif
            n.manche = res;
            n.partita = 0;
            if (res != 0) begin
                n.rounds = m.rounds + 1;
                if (res == 1) n.lead = m.lead + 1;
                if (res == 2) n.lead = m.lead - 1;
                if (res == 1) begin n.lw = 1; n.lm = p; end
                else if (res == 2) begin n.lw = 2; n.lm = s; end
                else begin n.lw = 0; n.lm = 0; end
                if ((n.rounds >= 4 && (n.lead >= 2 || n.lead <= -2)) || n.rounds == n.maxr) begin
                    if (n.lead > 0) begin n.phase = 2; n.partita = 1; end
                    else if (n.lead < 0) begin n.phase = 3; n.partita = 2; end
                    else begin n.phase = 4; n.partita = 3; end
                end
            end
        end else if (m.phase >= 2) begin
            n.manche = 0;
        end
        return n;
    endfunction

    function automatic logic [4:0] onehot(int ph);
        logic [4:0] v = 5'b00001;
        return v << ph;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check next_state, clock, check registered outputs.
    task automatic cycle(input bit r, input bit ini, input logic [1:0] p, input logic [1:0] s);
        model_t pred;
        rst = r; bus.INIZIA = ini; bus.PRIMO = p; bus.SECONDO = s;
        #1;
        if (!r) begin
            pred = step(model, 1'b0, ini, int'(p), int'(s));
            check("next_state", next_state, onehot(pred.phase));
        end
        @(posedge clk);
        model = step(model, r, ini, int'(p), int'(s));
        #1;
        check("current_state", current_state, onehot(model.phase));
        check("MANCHE", {3'b000, bus.MANCHE}, model.manche[4:0]);
        check("PARTITA", {3'b000, bus.PARTITA}, model.partita[4:0]);
    endtask

    initial begin
        rst = 1'b1; bus.INIZIA = 1'b0; bus.PRIMO = 2'b00; bus.SECONDO = 2'b00;
        model = step(model, 1'b1, 1'b0, 0, 0);
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 2'b00, 2'b00);
        check("reset state", current_state, 5'b00001);
        check("reset MANCHE", {3'b000, bus.MANCHE}, 5'd0);
        check("reset PARTITA", {3'b000, bus.PARTITA}, 5'd0);
        cycle(1'b0, 1'b0, 2'b01, 2'b11);
        check("idle hold", current_state, 5'b00001);

        // Round limit 10, three rounds, then ties until the limit hands P2 the game.
        cycle(1'b0, 1'b1, 2'b01, 2'b10);
        check("start PLAY", current_state, 5'b00010);
        check("start MANCHE", {3'b000, bus.MANCHE}, 5'd0);
        cycle(1'b0, 1'b0, 2'b10, 2'b01);
        check("paper>rock", {3'b000, bus.MANCHE}, 5'd1);
        cycle(1'b0, 1'b0, 2'b11, 2'b01);
        check("rock>scissors", {3'b000, bus.MANCHE}, 5'd2);
        cycle(1'b0, 1'b0, 2'b01, 2'b10);
        check("paper>rock p2", {3'b000, bus.MANCHE}, 5'd2);
        check("in play PARTITA", {3'b000, bus.PARTITA}, 5'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 2'b11, 2'b11);
        check("round 9 still PLAY", current_state, 5'b00010);
        cycle(1'b0, 1'b0, 2'b10, 2'b10);
        check("limit 10 P2WIN", current_state, 5'b01000);
        check("limit 10 PARTITA", {3'b000, bus.PARTITA}, 5'd2);

        // Four straight P1 wins with limit 4.
        cycle(1'b0, 1'b1, 2'b00, 2'b00);
        cycle(1'b0, 1'b0, 2'b10, 2'b01);
        cycle(1'b0, 1'b0, 2'b01, 2'b11);
        cycle(1'b0, 1'b0, 2'b11, 2'b10);
        check("r3 PARTITA", {3'b000, bus.PARTITA}, 5'd0);
        cycle(1'b0, 1'b0, 2'b10, 2'b01);
        check("P1WIN state", current_state, 5'b00100);
        check("P1WIN PARTITA", {3'b000, bus.PARTITA}, 5'd1);
        check("P1WIN last MANCHE", {3'b000, bus.MANCHE}, 5'd1);

        // Four ties -> draw, then moves ignored.
        cycle(1'b0, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b01, 2'b01);
        check("DRAW state", current_state, 5'b10000);
        check("DRAW PARTITA", {3'b000, bus.PARTITA}, 5'd3);
        cycle(1'b0, 1'b0, 2'b10, 2'b01);
        check("after DRAW MANCHE", {3'b000, bus.MANCHE}, 5'd0);
        check("after DRAW PARTITA", {3'b000, bus.PARTITA}, 5'd3);

        // Invalid round and repeated winning move.
        cycle(1'b0, 1'b1, 2'b00, 2'b00);
        cycle(1'b0, 1'b0, 2'b00, 2'b01);
        check("invalid MANCHE", {3'b000, bus.MANCHE}, 5'd0);
        cycle(1'b0, 1'b0, 2'b10, 2'b01);
        check("P1 paper", {3'b000, bus.MANCHE}, 5'd1);
        cycle(1'b0, 1'b0, 2'b10, 2'b11);
`ifdef MORRA_NO_REPEAT_EN
        check("repeat rejected", {3'b000, bus.MANCHE}, 5'd0);
`else
        check("repeat accepted", {3'b000, bus.MANCHE}, 5'd2);
`endif

        // Reset together with INIZIA mid-game, then limit 5.
        cycle(1'b1, 1'b1, 2'b01, 2'b01);
        check("rst>INIZIA state", current_state, 5'b00001);
        check("rst MANCHE", {3'b000, bus.MANCHE}, 5'd0);
        check("rst PARTITA", {3'b000, bus.PARTITA}, 5'd0);
        cycle(1'b0, 1'b1, 2'b00, 2'b01);
        check("limit5 PLAY", current_state, 5'b00010);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b11, 2'b11);
        check("limit5 r4 PLAY", current_state, 5'b00010);
        cycle(1'b0, 1'b0, 2'b10, 2'b10);
        check("limit5 DRAW", current_state, 5'b10000);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit ini;
            r = ($urandom_range(0, 199) == 0);
            if (model.phase == 0) ini = ($urandom_range(0, 3) == 0);
            else if (model.phase >= 2) ini = ($urandom_range(0, 2) == 0);
            else ini = ($urandom_range(0, 49) == 0);
            cycle(r, ini, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
